mips_cpu_mem_bus: RTL and testbench
===================================

# mips_cpu_mem_bus

Memory-side counterpart of the multi-cycle controller. It accepts one load/store request per handshake from the datapath and runs it as an Avalon-MM master transaction, honouring `waitrequest`. Byte and halfword lane steering and load sign/zero extension happen here. It returns completion, and load data, to the controller, which holds its current state until `resp_valid`.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width on both sides.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 illegal.
- `req_signed`  in  1  sign-extend load result; ignored for words and stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with `resp_valid`; misaligned or illegal request.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors; held until the next `resp_valid`.
- `address`  out  ADDR_W  Avalon word address; bits [1:0] always 0.
- `read`, `write`  out  1  Avalon strobes.
- `byteenable`  out  4  Avalon lane enables.
- `writedata`  out  32  Avalon write data.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  32  slave read data, valid in the cycle where `read && !waitrequest`.

## Operation
- Lanes are little-endian: byte offset n = `req_addr[1:0]` maps to bits [8n+7:8n] and `byteenable[n]`.
- Byte access: enable `1<<n`. Half access: enable `4'b0011 << n`. Word access: enable `4'b1111`.
- Store data is shifted left by 8n; unused lanes are driven 0.
- Load data is taken from lane n, then zero- or sign-extended per `req_signed`. Words pass through unchanged.
- Error conditions are `req_size==3`, a half with `addr[0]` set, or a word with `addr[1:0]!=0`. On error:
  - no Avalon strobe is issued;
  - the block goes to RESP with `resp_err=1`, `resp_rdata=0`.
- FSM states are IDLE, BUS, RESP.
  - IDLE → BUS on an accepted legal request. All bus outputs, and the size/signed/offset fields, are registered at this point.
  - IDLE → RESP on an accepted illegal request.
  - BUS holds while `waitrequest=1`; `read`/`write`, `address`, `byteenable` and `writedata` stay stable throughout.
  - BUS → RESP in the cycle `waitrequest=0`. Strobes drop on the same edge, and `readdata` is captured and extended on that edge.
  - RESP → IDLE unconditionally; `resp_valid=1` only in RESP.
- All outputs are registered. `read` and `write` are never high together.
- `req_*` inputs are sampled only at acceptance; they may change afterwards.

## Timing
- Reset values: `read`=`write`=0, `address`=0, `byteenable`=0, `writedata`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, state IDLE, `req_ready`=1 from the cycle after reset.
- Reset asserted mid-transaction abandons it. Strobes are 0 from the next edge, and no `resp_valid` is ever issued for the abandoned request.
- Legal request with zero wait, accepted at edge 0:
  - strobe high in cycle 1 (after edge 0);
  - `resp_valid` in cycle 2;
  - `req_ready` high again in cycle 3.
- Each cycle of `waitrequest` adds exactly one cycle to that latency.
- Illegal request accepted at edge 0 gives `resp_valid`/`resp_err` in cycle 1.
- Back-to-back: the earliest next acceptance is the cycle after RESP. Bus throughput is at most one transaction per 3 cycles.
- `waitrequest` is ignored outside BUS.

## Structure
- Shared package `mips_cpu_pkg`: `mem_size_t` enum (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`) and the FSM state enum `mem_bus_state_t`.
- Sub-module `mips_cpu_lane_align` (combinational):
  - store direction: size, offset, wdata → byteenable, shifted writedata, misalign flag;
  - load direction: size, signed, offset, readdata → extended result.
- The top level holds the FSM and the registers.

## Test plan
- LW 0x0000_1000, `waitrequest` high 2 cycles, `readdata`=0xDEADBEEF → `address`=0x1000, `byteenable`=1111, `read` high cycles 1–3, `resp_valid` cycle 4, `resp_rdata`=0xDEADBEEF.
- LB signed 0x0000_2003, `readdata`=0x80AABBCC → `byteenable`=1000, `resp_rdata`=0xFFFFFF80. The same request with LBU → 0x00000080.
- SH 0x0000_0102, `req_wdata`=0x0000_1234 → `address`=0x100, `byteenable`=1100, `writedata`=0x1234_0000, `write` for one cycle, `resp_err`=0.
- LW 0x0000_1001, then `req_size`=3 → no strobe; `resp_valid`+`resp_err` in cycle 1; `resp_rdata`=0.
- Reset asserted during BUS with `waitrequest` held → strobes 0 next cycle, no `resp_valid`, `req_ready`=1 after release. A following LW completes normally.
- Back-to-back SW then LW with `req_valid` held → second acceptance exactly one cycle after the first `resp_valid`. `read` and `write` are never high together.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types for the multi-cycle CPU memory-side blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mem_size_t (access size encoding), mem_bus_state_t (bus FSM states).
package mips_cpu_pkg;

  // Access size as carried on req_size. Encoding 2'd3 is deliberately absent:
  // it is the illegal size and is flagged as an error by the lane aligner.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mem_bus_state_t;

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Byte/halfword lane steering for stores and lane extraction plus extension for loads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: st_* = store direction (size, byte offset, right-justified data -> byteenable,
//        lane-shifted data, misalign/illegal flag); ld_* = load direction (size, signed,
//        byte offset, raw readdata -> extended result).
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byteenable,
  output logic [31:0] st_wdata_sh,
  output logic        st_misalign,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [4:0]  st_shamt;
  logic [4:0]  ld_shamt;
  logic [31:0] ld_shift;

  assign st_shamt = {st_offset, 3'b000};
  assign ld_shamt = {ld_offset, 3'b000};
  // Bring the addressed lane down to bit 0; legal words always have offset 0.
  assign ld_shift = ld_rdata >> ld_shamt;

  always_comb begin
    st_byteenable = 4'b0000;
    st_wdata_sh   = 32'h0;
    st_misalign   = 1'b1;
    case (st_size)
      SIZE_BYTE: begin
        st_byteenable = 4'b0001 << st_offset;
        st_wdata_sh   = {24'h0, st_wdata[7:0]} << st_shamt;
        st_misalign   = 1'b0;
      end
      SIZE_HALF: begin
        st_byteenable = 4'b0011 << st_offset;
        st_wdata_sh   = {16'h0, st_wdata[15:0]} << st_shamt;
        st_misalign   = st_offset[0];
      end
      SIZE_WORD: begin
        st_byteenable = 4'b1111;
        st_wdata_sh   = st_wdata;
        st_misalign   = (st_offset != 2'b00);
      end
      default: begin
        // Illegal size: no lanes, flagged as an error.
        st_byteenable = 4'b0000;
        st_wdata_sh   = 32'h0;
        st_misalign   = 1'b1;
      end
    endcase
  end

  always_comb begin
    ld_result = ld_shift;
    case (ld_size)
      SIZE_BYTE: ld_result = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      SIZE_HALF: ld_result = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      default:   ld_result = ld_shift;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_bus.sv
// Runs one load/store request from the controller as an Avalon-MM master transaction.
// Latency: legal request -> resp_valid 2 cycles after acceptance (+1 per waitrequest cycle);
//          illegal request -> resp_valid 1 cycle after acceptance.
// Backpressure: req_ready only in IDLE; Avalon waitrequest stalls in BUS with outputs held.
// Ports: clk/reset (sync, active-high); req_* request handshake from the controller;
//        resp_* one-cycle completion pulse with error flag and extended load data;
//        address/read/write/byteenable/writedata/waitrequest/readdata Avalon-MM master side.
module mips_cpu_mem_bus
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  mem_bus_state_t    state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        offset_q, offset_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              st_misalign;
  logic [31:0]       ld_result;

  // Store side works on the live request (registered at acceptance); load side works
  // on the fields captured at acceptance and the live readdata at the completing edge.
  mips_cpu_lane_align u_lane_align (
    .st_size       (req_size),
    .st_offset     (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_byteenable (st_be),
    .st_wdata_sh   (st_wdata),
    .st_misalign   (st_misalign),
    .ld_size       (size_q),
    .ld_signed     (signed_q),
    .ld_offset     (offset_q),
    .ld_rdata      (readdata),
    .ld_result     (ld_result)
  );

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    offset_d     = offset_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (st_misalign) begin
            // Error path skips the bus entirely.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d      = ST_BUS;
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            read_d       = ~req_write;
            write_d      = req_write;
            byteenable_d = st_be;
            writedata_d  = st_wdata;
            size_d       = req_size;
            signed_d     = req_signed;
            offset_d     = req_addr[1:0];
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          state_d      = ST_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_q ? ld_result : 32'h0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      byteenable_q <= 4'b0000;
      writedata_q  <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      offset_q     <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      offset_q     <= offset_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_mips_cpu_mem_bus.sv
// Self-checking bench for mips_cpu_mem_bus: directed cases plus random requests against
// an arithmetic reference model of lane steering, extension and error rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mips_cpu_mem_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;
  logic rw_both = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_mem_bus #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always @(negedge clk) if (read && write) rw_both = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: sizes as byte counts, lanes as byte offsets, masks by arithmetic.
  function automatic void model(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic err, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] ld);
    int nb, off;
    logic [63:0] m, v, w64, r64;
    off = int'(a % 32'd4);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((off % nb) != 0);
    m   = (64'd1 << (8 * nb)) - 64'd1;
    be  = 4'(((1 << nb) - 1) << off);
    w64 = {32'h0, wd};
    wdo = 32'((w64 & m) << (8 * off));
    r64 = {32'h0, rd};
    v   = (r64 >> (8 * off)) & m;
    if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~m;
    ld  = v[31:0];
  endfunction

  task automatic scramble_req();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Starts at a falling edge with the DUT idle; ends at a falling edge with the DUT idle.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int nw,
                        input logic [31:0] rd);
    logic e;
    logic [3:0] be;
    logic [31:0] wdo, ld, exp_rd;
    model(sz, sg, a, wd, rd, e, be, wdo, ld);
    exp_rd = (e || w) ? 32'h0 : ld;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    chk({tag, "/ready_in"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    scramble_req();
    if (!e) begin
      for (int i = 0; i <= nw; i++) begin
        chk({tag, "/read"}, 32'(read), 32'(!w));
        chk({tag, "/write"}, 32'(write), 32'(w));
        chk({tag, "/address"}, address, a & 32'hFFFF_FFFC);
        chk({tag, "/byteenable"}, 32'(byteenable), 32'(be));
        if (w) chk({tag, "/writedata"}, writedata, wdo);
        chk({tag, "/no_resp"}, 32'(resp_valid), 32'd0);
        chk({tag, "/busy"}, 32'(req_ready), 32'd0);
        waitrequest = (i < nw);
        readdata    = (i == nw) ? rd : $urandom;
        @(negedge clk);
      end
    end
    waitrequest = 1'($urandom);
    readdata    = $urandom;
    chk({tag, "/strobe_off"}, 32'({read, write}), 32'd0);
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "/resp_err"}, 32'(resp_err), 32'(e));
    chk({tag, "/resp_rdata"}, resp_rdata, exp_rd);
    @(negedge clk);
    chk({tag, "/resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "/ready_out"}, 32'(req_ready), 32'd1);
    chk({tag, "/rdata_held"}, resp_rdata, exp_rd);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; waitrequest = 1'b1; readdata = 32'h0;
    scramble_req();
    @(negedge clk);
    @(negedge clk);
    chk("rst/read", 32'(read), 32'd0);
    chk("rst/write", 32'(write), 32'd0);
    chk("rst/address", address, 32'd0);
    chk("rst/byteenable", 32'(byteenable), 32'd0);
    chk("rst/writedata", writedata, 32'd0);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/resp_err", 32'(resp_err), 32'd0);
    chk("rst/resp_rdata", resp_rdata, 32'd0);
    chk("rst/ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_req("lw_wait2", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 2, 32'hDEAD_BEEF);
    chk("lw_wait2/value", resp_rdata, 32'hDEAD_BEEF);
    do_req("lb_signed", 1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0, 0, 32'h80AA_BBCC);
    chk("lb_signed/value", resp_rdata, 32'hFFFF_FF80);
    do_req("lbu", 1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0, 0, 32'h80AA_BBCC);
    chk("lbu/value", resp_rdata, 32'h0000_0080);
    do_req("sh", 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_1234, 0, 32'h0);
    do_req("lw_misaligned", 1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0, 0, 32'h0);
    do_req("size3", 1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0, 0, 32'h0);
    do_req("lh_signed_hi", 1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0, 1, 32'h8001_7FFF);

    // Reset while the bus is stalled: the transaction is dropped silently.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_3000;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort/read_up", 32'(read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort/strobes", 32'({read, write}), 32'd0);
    chk("abort/no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort/ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort/still_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req("after_abort", 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h1234_5678);

    // Back-to-back with req_valid held: SW then LW.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0000_4000;
    req_wdata = 32'hCAFE_F00D; waitrequest = 1'b0;
    @(negedge clk);
    chk("b2b/sw_write", 32'(write), 32'd1);
    chk("b2b/sw_data", writedata, 32'hCAFE_F00D);
    req_write = 1'b0; req_addr = 32'h0000_4004; readdata = 32'h0BAD_CAFE;
    @(negedge clk);
    chk("b2b/sw_resp", 32'(resp_valid), 32'd1);
    chk("b2b/not_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b/ready_after_resp", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b/lw_read", 32'(read), 32'd1);
    chk("b2b/lw_addr", address, 32'h0000_4004);
    @(negedge clk);
    chk("b2b/lw_resp", 32'(resp_valid), 32'd1);
    chk("b2b/lw_data", resp_rdata, 32'h0BAD_CAFE);
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (a[2]) ? 2'b00 : a[1:0];
      do_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)), $urandom);
    end

    chk("rw_exclusive", 32'(rw_both), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
